mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
- Sequencing controller for the unsigned shift-add multiplier datapath: product register, multiplicand register and ALU adder.
- Accepts a multiply request through a valid/ready handshake and loads the operands.
- Drives the product register's load and add/shift controls for WIDTH iterations, then pulses rdy for one cycle while the 64-bit product is valid.
- Sits between the issuing unit (CPU/ALU front end) and the multiplier datapath.

Parameters:
- WIDTH, 32, operand width; the number of add/shift iterations.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  requester has operands on the datapath inputs
- req_ready  out  1  controller can accept a request
- ld_mcand  out  1  multiplicand register load enable; high on the handshake cycle
- alu_zero  out  1  forces the ALU result to 0 and its carry to 0 during the product load
- w_ctrl_Product  out  1  product register control: 0 = load {carry, alu, multiplier}, 1 = shift/add
- adding_ctrl  out  1  product register: 1 = add then shift, 0 = shift only
- lsb  in  1  product register bit 0 (current multiplier bit)
- busy  out  1  operation in progress (LOAD or RUN)
- rdy  out  1  one-cycle pulse; product_out is valid in this cycle
- iter_cnt  out  CNT_W  current iteration index, for debug/verification

Behaviour:
- States: IDLE, LOAD, RUN, DONE. State is held in a register; busy, rdy, alu_zero and w_ctrl_Product are decoded from the state register only.
- Reset:
  - state=IDLE, cnt=0.
  - While rst is high: req_ready=0, ld_mcand=0, adding_ctrl=0.
  - After the reset edge: rdy=0, busy=0, alu_zero=0, w_ctrl_Product=1.
- IDLE:
  - req_ready=1, w_ctrl_Product=1, adding_ctrl=0.
  - The product register may keep shifting in IDLE; its content is don't-care here.
  - When req_valid=1: ld_mcand=1 in the same cycle (Mealy), next state LOAD.
- LOAD (1 cycle):
  - w_ctrl_Product=0, alu_zero=1, busy=1, req_ready=0.
  - The product register captures {0, 0, multiplier}. cnt<=0. Next state RUN.
- RUN (exactly WIDTH cycles):
  - w_ctrl_Product=1, busy=1, adding_ctrl=lsb (combinational, same cycle).
  - cnt increments every cycle.
  - When cnt==WIDTH-1: next state DONE, cnt<=0.
- DONE (1 cycle):
  - rdy=1, adding_ctrl=0, w_ctrl_Product=1.
  - The product register holds the final 64-bit result for this cycle only. The datapath has no hold, so the consumer must capture on rdy.
  - req_ready=1 in DONE. If req_valid=1: ld_mcand=1, next state LOAD (back-to-back issue). Otherwise next state IDLE.
- Latency: handshake at cycle T, product valid and rdy=1 at T+WIDTH+2. Throughput is one multiply per WIDTH+2 cycles.
- adding_ctrl is forced to 0 outside RUN, even if lsb is X.
- req_valid is ignored in LOAD and RUN. There is no queueing; the requester must hold req_valid until it sees req_ready.
- Reset mid-operation (LOAD/RUN/DONE): IDLE on the next edge; no rdy pulse for the aborted operation.
- Counter saturation is impossible: cnt is cleared on entry to RUN and on exit to DONE.
- Assertions:
  - rdy and busy are mutually exclusive.
  - rdy pulses are never longer than 1 cycle.
  - w_ctrl_Product=0 only in LOAD.

Decomposition:
- Package mult_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - the WIDTH default of 32;
  - a localparam LAST_ITER = WIDTH-1.
- One natural sub-module, mult_iter_cnt: a clearable, enabled up-counter with a terminal-count flag. The FSM and output decode stay in mult_seq_ctrl.

Test Plan:
- Basic 3×5: bench uses the product register plus ALU model.
  - Request 3×5 → adding_ctrl high in RUN cycles 0 and 2 only.
  - rdy at T+34, product_out=0x0000_0000_0000_000F.
- Max operands 0xFFFFFFFF × 0xFFFFFFFF → adding_ctrl high all 32 RUN cycles; at rdy, product_out=0xFFFF_FFFE_0000_0001.
- Zero multiplier 0x1234 × 0 → adding_ctrl never high; at rdy, product_out=0.
- Back-to-back: req_valid held high across two ops (7×9, then 2×8).
  - Second handshake occurs in the DONE cycle of the first; no IDLE cycle between them.
  - rdy pulses exactly 34 cycles apart, results 63 then 16.
- Busy ignore: req_valid pulsed during RUN cycle 10 → no ld_mcand; result unaffected.
- Reset mid-operation: rst asserted at RUN cycle 15.
  - Next cycle: IDLE, busy=0, no rdy pulse.
  - A new request 6×7 afterwards yields 42.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// Imported by the controller and its iteration counter.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;
    localparam int LAST_ITER = DEF_WIDTH - 1;

    function automatic int last_iter(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Clearable, enabled up-counter with a terminal-count flag.
// Clear has priority over enable.
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int LAST  = LAST_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(LAST));

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing FSM for the unsigned shift-add multiplier datapath.
// Loads operands, runs WIDTH add/shift steps, pulses rdy with the product.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             ld_mcand,
    output logic             alu_zero,
    output logic             w_ctrl_Product,
    output logic             adding_ctrl,
    input  logic             lsb,
    output logic             busy,
    output logic             rdy,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam int LAST = last_iter(WIDTH);

    state_t state;
    logic   in_run;
    logic   in_load;
    logic   cnt_tc;
    logic   cnt_clr;

    assign in_run  = (state == RUN);
    assign in_load = (state == LOAD);

    // Mealy handshake: the requester sees ready and the operand load in the same cycle
    assign req_ready   = !rst && ((state == IDLE) || (state == DONE));
    assign ld_mcand    = req_ready && req_valid;
    assign adding_ctrl = !rst && in_run && lsb;

    assign busy           = in_load || in_run;
    assign rdy            = (state == DONE);
    assign alu_zero       = in_load;
    assign w_ctrl_Product = !in_load;

    assign cnt_clr = in_load || (in_run && cnt_tc);

    mult_iter_cnt #(
        .CNT_W (CNT_W),
        .LAST  (LAST)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (in_run),
        .cnt (iter_cnt),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (req_valid) state <= LOAD;
                LOAD: state <= RUN;
                RUN:  if (cnt_tc) state <= DONE;
                DONE: state <= req_valid ? LOAD : IDLE;
            endcase
        end
    end

    a_rdy_busy_excl: assert property (
        @(posedge clk) disable iff (rst) !(rdy && busy));

    a_rdy_single: assert property (
        @(posedge clk) disable iff (rst) rdy |=> !rdy);

    a_load_only: assert property (
        @(posedge clk) disable iff (rst) !w_ctrl_Product |-> alu_zero);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl with a behavioural product-register/ALU model.
// Results are compared against plain a*b arithmetic.
module tb_mult_seq_ctrl;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          ld_mcand;
    logic          alu_zero;
    logic          w_ctrl;
    logic          adding_ctrl;
    logic          lsb;
    logic          busy;
    logic          rdy;
    logic [CW-1:0] iter_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .ld_mcand       (ld_mcand),
        .alu_zero       (alu_zero),
        .w_ctrl_Product (w_ctrl),
        .adding_ctrl    (adding_ctrl),
        .lsb            (lsb),
        .busy           (busy),
        .rdy            (rdy),
        .iter_cnt       (iter_cnt)
    );

    // Datapath model: multiplicand register, 65-bit product register, adder
    logic [31:0] mcand_in = '0;
    logic [31:0] mplier_in = '0;
    logic [31:0] mcand_q = '0;
    logic [31:0] mplier_q = '0;
    logic [64:0] prod = 65'h1;
    logic [63:0] product_out;

    always @(posedge clk) begin
        if (ld_mcand === 1'b1) begin
            mcand_q  <= mcand_in;
            mplier_q <= mplier_in;
        end
        if (w_ctrl === 1'b0)
            prod <= {33'b0, mplier_q};
        else if (adding_ctrl === 1'b1)
            prod <= {({1'b0, prod[63:32]} + {1'b0, mcand_q}), prod[31:0]} >> 1;
        else
            prod <= prod >> 1;
    end

    assign lsb         = prod[0];
    assign product_out = prod[63:0];

    // Which RUN steps performed an add, indexed by iteration
    logic [31:0] add_mask = '0;
    int          run_idx = 0;
    int          cnt_bad = 0;
    int          prop_bad = 0;
    logic        prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (alu_zero === 1'b1) begin
                add_mask <= '0;
                run_idx  <= 0;
            end else if (busy === 1'b1) begin
                if (adding_ctrl === 1'b1)
                    add_mask[iter_cnt[4:0]] <= 1'b1;
                if (iter_cnt !== CW'(run_idx))
                    cnt_bad <= cnt_bad + 1;
                run_idx <= run_idx + 1;
            end
            if ((rdy && busy) || (rdy && prev_rdy) || (!w_ctrl && !alu_zero))
                prop_bad <= prop_bad + 1;
        end
        prev_rdy <= rdy;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_hs(output int t);
        bit ok;
        ok = 0;
        t  = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1;
                t  = cyc;
                break;
            end
        end
        chk("hs_wait", 64'(ok), 64'd1);
    endtask

    task automatic wait_rdy(output int t);
        bit ok;
        ok = 0;
        t  = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                ok = 1;
                t  = cyc;
                break;
            end
        end
        chk("rdy_wait", 64'(ok), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input bit pulse);
        int t0;
        int t;
        @(posedge clk);
        #1;
        mcand_in  = a;
        mplier_in = b;
        req_valid = 1'b1;
        wait_hs(t0);
        chk("ld_mcand_hs", 64'(ld_mcand), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("load_wctrl", 64'(w_ctrl), 64'd0);
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_ready", 64'(req_ready), 64'd0);
        if (pulse) begin
            repeat (11) @(posedge clk);
            #1;
            req_valid = 1'b1;
            mcand_in  = ~a;
            mplier_in = ~b;
            @(negedge clk);
            chk("ignore_idx", 64'(iter_cnt), 64'd10);
            chk("ignore_ld", 64'(ld_mcand), 64'd0);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
        wait_rdy(t);
        chk("latency", 64'(t - t0), 64'(W + 2));
        chk("product", product_out, 64'(a) * 64'(b));
        chk("add_mask", 64'(add_mask), 64'(b));
        chk("done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("after_rdy", 64'(rdy), 64'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int t2;
        int seen;

        // Reset behaviour, with a request pending to exercise gating
        req_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_ld", 64'(ld_mcand), 64'd0);
        chk("rst_add", 64'(adding_ctrl), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_azero", 64'(alu_zero), 64'd0);
        chk("rst_wctrl", 64'(w_ctrl), 64'd1);
        chk("rst_cnt", 64'(iter_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        do_op(32'd3, 32'd5, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(32'h1234, 32'd0, 1'b0);

        // Back-to-back: req_valid held through the first DONE cycle
        @(posedge clk);
        #1;
        mcand_in  = 32'd7;
        mplier_in = 32'd9;
        req_valid = 1'b1;
        wait_hs(t0);
        @(posedge clk);
        #1;
        mcand_in  = 32'd2;
        mplier_in = 32'd8;
        wait_rdy(t1);
        chk("b2b_lat1", 64'(t1 - t0), 64'(W + 2));
        chk("b2b_prod1", product_out, 64'd63);
        chk("b2b_mask1", 64'(add_mask), 64'd9);
        chk("b2b_ld", 64'(ld_mcand), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_noidle", 64'(alu_zero), 64'd1);
        wait_rdy(t2);
        chk("b2b_gap", 64'(t2 - t1), 64'(W + 2));
        chk("b2b_prod2", product_out, 64'd16);

        // Request pulsed in RUN cycle 10 must be ignored
        do_op(32'hDEAD_BEEF, 32'h0F0F_1234, 1'b1);
        @(negedge clk);
        chk("ignore_idle", 64'(busy), 64'd0);

        // Reset in RUN cycle 15 aborts without a rdy pulse
        @(posedge clk);
        #1;
        mcand_in  = 32'h55;
        mplier_in = 32'hAB;
        req_valid = 1'b1;
        wait_hs(t0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idx", 64'(iter_cnt), 64'd15);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cnt", 64'(iter_cnt), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (rdy === 1'b1) seen++;
            @(negedge clk);
        end
        chk("abort_no_rdy", 64'(seen), 64'd0);
        do_op(32'd6, 32'd7, 1'b0);

        for (int k = 0; k < 4; k++) begin
            do_op($urandom, $urandom, 1'b0);
        end

        chk("iter_track", 64'(cnt_bad), 64'd0);
        chk("props", 64'(prop_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
